// File: rtl/sipo_packer.sv
// Serial-in/parallel-out packer: gathers DEPTH beats into one word behind a single output slot.
// Optional o_parity port is built when SIPO_PACKER_PARITY_EN is defined.
module sipo_packer #(
    parameter int DATA_IN_W  = 1,
    parameter int DATA_OUT_W = 8,
    parameter int MSB_FIRST  = 0
) (
    input  logic                                       i_clk,
    input  logic                                       i_rst,
    input  logic                                       i_valid,
    output logic                                       o_ready,
    input  logic [DATA_IN_W-1:0]                       i_data,
    input  logic                                       i_flush,
    output logic                                       o_valid,
    input  logic                                       i_ready,
    output logic [DATA_OUT_W-1:0]                      o_data,
    output logic                                       o_partial,
`ifdef SIPO_PACKER_PARITY_EN
    output logic                                       o_parity,
`endif
    output logic [$clog2(DATA_OUT_W/DATA_IN_W+1)-1:0]  o_fill
);

    localparam int DEPTH  = DATA_OUT_W / DATA_IN_W;
    localparam int FILL_W = $clog2(DEPTH + 1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    logic [DATA_OUT_W-1:0] acc_q, acc_d, acc_w;
    logic [FILL_W-1:0]     fill_q, fill_d, fill_w;
    logic                  pend_q, pend_d;
    logic [DATA_OUT_W-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  partial_q, partial_d;
`ifdef SIPO_PACKER_PARITY_EN
    logic                  parity_q, parity_d;
`endif
    logic                  accept, pop, slot_free, flush_act, load;
    int                    lane;

    always_comb begin
        o_ready   = ~i_rst & (fill_q != FULL);
        accept    = i_valid & o_ready;
        pop       = valid_q & i_ready;
        slot_free = ~valid_q | pop;
        flush_act = pend_q | i_flush;
        lane      = (MSB_FIRST != 0) ? (DEPTH - 1 - int'(fill_q)) : int'(fill_q);

        // Accumulator view including this cycle's beat, so a same-cycle flush or fill sees it.
        acc_w = acc_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && lane == i) begin
                acc_w[i*DATA_IN_W +: DATA_IN_W] = i_data;
            end
        end
        fill_w = fill_q + FILL_W'(accept);
        load   = slot_free & ((fill_w == FULL) | (flush_act & (fill_w != '0)));

        acc_d     = acc_w;
        fill_d    = fill_w;
        pend_d    = flush_act & (fill_w != '0);
        data_d    = data_q;
        partial_d = partial_q;
        valid_d   = valid_q & ~pop;
`ifdef SIPO_PACKER_PARITY_EN
        parity_d  = parity_q;
`endif
        if (load) begin
            // Clearing lanes on load keeps unfilled lanes zero for the next partial flush.
            acc_d     = '0;
            fill_d    = '0;
            pend_d    = 1'b0;
            data_d    = acc_w;
            partial_d = (fill_w != FULL);
            valid_d   = 1'b1;
`ifdef SIPO_PACKER_PARITY_EN
            parity_d  = ^acc_w;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q     <= '0;
            fill_q    <= '0;
            pend_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
`ifdef SIPO_PACKER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            pend_q    <= pend_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            partial_q <= partial_d;
`ifdef SIPO_PACKER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_partial = partial_q;
    assign o_fill    = fill_q;
`ifdef SIPO_PACKER_PARITY_EN
    assign o_parity  = parity_q;
`endif

endmodule

// File: doc/sipo_packer.md
SIPO_PACKER -- requirements
Module: sipo_packer

Interface
REQ-001 Parameter DATA_IN_W, default 1, input beat width in bits.
REQ-002 Parameter DATA_OUT_W, default 8, output word width; an integer multiple of DATA_IN_W, DEPTH = DATA_OUT_W/DATA_IN_W >= 2.
REQ-003 Parameter MSB_FIRST, default 0; 0 = first beat lands in lane 0 (LSBs), 1 = first beat lands in lane DEPTH-1 (MSBs).
REQ-004 i_clk  input  1  single clock; all state on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_valid  input  1  input beat present.
REQ-007 o_ready  output  1  block accepts a beat this cycle (beat taken when i_valid & o_ready).
REQ-008 i_data  input  DATA_IN_W  input beat.
REQ-009 i_flush  input  1  request to emit the partially filled word.
REQ-010 o_valid  output  1  output word present.
REQ-011 i_ready  input  1  downstream accepts word (transfer when o_valid & i_ready).
REQ-012 o_data  output  DATA_OUT_W  packed word; stable while o_valid & ~i_ready.
REQ-013 o_partial  output  1  current o_data came from a flush with fewer than DEPTH beats.
REQ-014 o_fill  output  $clog2(DEPTH+1)  beats currently held in the accumulator.

Function
REQ-015 The block SHALL hold an accumulator (DEPTH lanes plus fill counter) and a one-word registered output slot.
REQ-016 Each accepted beat SHALL be written to the lane indexed by the fill count (reversed when MSB_FIRST=1), and the fill count SHALL increment.
REQ-017 When the DEPTH-th beat is accepted and the slot is empty or popped in the same cycle, the word SHALL move to the slot at that edge: o_valid=1 the next cycle (latency 1), fill count returns to 0, o_partial=0.
REQ-018 If the slot is occupied and not popped, the complete word SHALL remain in the accumulator and o_ready SHALL be 0 until the slot frees; the word moves on the edge the slot is popped.
REQ-019 o_ready SHALL be 1 whenever the accumulator is not full; with i_ready held 1 the block sustains one beat per cycle with no bubbles.
REQ-020 i_flush SHALL set a pending-flush flag; it executes on the first cycle when fill (including a beat accepted that cycle) is > 0 and the slot is free or being popped.
REQ-021 A flush SHALL move the accumulator to the slot with unfilled lanes zero, set o_partial=1 when fill < DEPTH, clear the fill count and the pending flag.
REQ-022 A flush with fill = 0 and no beat accepted that cycle SHALL clear the pending flag and emit nothing.
REQ-023 A beat accepted in the same cycle as an executing flush SHALL be included in the flushed word.
REQ-024 o_data and o_partial SHALL change only when a word is loaded into the slot; a popped slot with nothing to load drives o_valid=0 and holds o_data.

Reset
REQ-025 While i_rst=1: o_valid=0, o_ready=0, o_data=0, o_partial=0, o_fill=0, all lanes 0, pending flush cleared.
REQ-026 o_ready SHALL be 1 in the first cycle after i_rst deasserts; reset mid-word SHALL discard partial and slotted data.

Configuration
REQ-027 Macro SIPO_PACKER_PARITY_EN defined: output port o_parity (1 bit) exists, equal to XOR of all o_data bits, registered with the slot and 0 at reset.
REQ-028 Macro SIPO_PACKER_PARITY_EN undefined: port o_parity and its logic SHALL be absent; all other behaviour identical.

Verification (defaults DATA_IN_W=1, DATA_OUT_W=8, i_ready=1 unless stated)
REQ-029 MSB_FIRST=0, beats 1,0,1,1,0,0,1,0 on consecutive cycles -> o_valid one cycle after 8th beat, o_data=8'h4D, o_partial=0.
REQ-030 MSB_FIRST=1, same beats -> o_data=8'hB2.
REQ-031 Beats 1,1,1 then i_flush pulse -> o_data=8'h07, o_partial=1, o_fill returns 0; with SIPO_PACKER_PARITY_EN o_parity=1.
REQ-032 i_ready=0, 17 beats offered continuously -> first word in slot, second fills accumulator, o_ready=0 after 16th accepted, 17th held; i_ready=1 for one cycle -> second word loaded next cycle, 17th accepted.
REQ-033 i_rst pulsed after 5 beats -> all outputs 0; next 8 beats 8'hFF pattern produce o_data=8'hFF with no residue from the aborted word.
REQ-034 i_flush with o_fill=0 -> no o_valid; then 8 beats -> normal full word, o_partial=0.
